// File: rtl/alu_exec_unit_pkg.sv
// Op encodings, widths and op-class helpers shared by the ALU execution unit
// and the reservation station / ROB side of the CDB.
`ifndef RBID
`define RBID 3:0
`endif

package alu_exec_unit_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int ROB_W_DEF = 4;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef enum logic [5:0] {
    OP_ADD    = 6'd0,  OP_SUB  = 6'd1,  OP_SLL  = 6'd2,  OP_SLT  = 6'd3,
    OP_SLTU   = 6'd4,  OP_XOR  = 6'd5,  OP_SRL  = 6'd6,  OP_SRA  = 6'd7,
    OP_OR     = 6'd8,  OP_AND  = 6'd9,  OP_BEQ  = 6'd10, OP_BNE  = 6'd11,
    OP_BLT    = 6'd12, OP_BGE  = 6'd13, OP_BLTU = 6'd14, OP_BGEU = 6'd15,
    OP_JALR   = 6'd16, OP_MUL  = 6'd17, OP_MULH = 6'd18, OP_MULHSU = 6'd19,
    OP_MULHU  = 6'd20
  } alu_op_e;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
    logic hi;
  } mul_mode_t;

  function automatic logic is_mul_op(input logic [5:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic mul_mode_t mul_mode(input logic [5:0] op);
    mul_mode_t m;
    m.a_signed = (op == OP_MULH) || (op == OP_MULHSU);
    m.b_signed = (op == OP_MULH);
    m.hi       = (op != OP_MUL);
    return m;
  endfunction
endpackage

// File: rtl/alu_exec_unit_mul_seq.sv
// Operand-latching multiplier used only in ALU_MUL_EN builds; the product is a
// multicycle path whose timing is owned by the exec unit's countdown FSM.
module alu_mul_seq
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  mul_mode_t       mode_i,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);
  logic [XLEN-1:0]   a_q, b_q;
  mul_mode_t         mode_q;
  logic              vld_q;
  logic [2*XLEN-1:0] ax, bx, full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      vld_q  <= 1'b0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      mode_q <= mode_i;
      vld_q  <= 1'b1;
    end
  end

  // Extending to 2*XLEN and multiplying modulo 2^(2*XLEN) yields the exact
  // signed/unsigned product for every signedness mix.
  assign ax        = {{XLEN{mode_q.a_signed & a_q[XLEN-1]}}, a_q};
  assign bx        = {{XLEN{mode_q.b_signed & b_q[XLEN-1]}}, b_q};
  assign full      = ax * bx;
  assign product_o = mode_q.hi ? full[2*XLEN-1:XLEN] : full[XLEN-1:0];
  assign done_o    = vld_q;
endmodule

// File: rtl/alu_exec_unit.sv
// RS->ALU issue endpoint: single-cycle integer/branch/JALR datapath driving the ALU CDB.
// Define ALU_MUL_EN to add the sequential multiplier with busy back-pressure.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ROB_W   = ROB_W_DEF,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             clr,
  input  logic             flag_alu,
  input  logic [5:0]       op_alu,
  input  logic [XLEN-1:0]  rs1_alu,
  input  logic [XLEN-1:0]  rs2_alu,
  input  logic [ROB_W-1:0] rob_alu,
  output logic             alu_busy,
  output logic             alu_ans_flag,
  output logic [ROB_W-1:0] alu_ans_reorder,
  output logic [XLEN-1:0]  alu_ans
);
  logic [XLEN-1:0]  res;
  logic [4:0]       sh;
  logic             flag_q;
  logic [ROB_W-1:0] tag_q;
  logic [XLEN-1:0]  ans_q;

  assign sh = rs2_alu[4:0];

  always_comb begin
    res = '0;
    case (op_alu)
      OP_ADD:  res = rs1_alu + rs2_alu;
      OP_SUB:  res = rs1_alu - rs2_alu;
      OP_SLL:  res = rs1_alu << sh;
      OP_SLT:  res = XLEN'($signed(rs1_alu) < $signed(rs2_alu));
      OP_SLTU: res = XLEN'(rs1_alu < rs2_alu);
      OP_XOR:  res = rs1_alu ^ rs2_alu;
      OP_SRL:  res = rs1_alu >> sh;
      OP_SRA:  res = $unsigned($signed(rs1_alu) >>> sh);
      OP_OR:   res = rs1_alu | rs2_alu;
      OP_AND:  res = rs1_alu & rs2_alu;
      OP_BEQ:  res = XLEN'(rs1_alu == rs2_alu);
      OP_BNE:  res = XLEN'(rs1_alu != rs2_alu);
      OP_BLT:  res = XLEN'($signed(rs1_alu) < $signed(rs2_alu));
      OP_BGE:  res = XLEN'($signed(rs1_alu) >= $signed(rs2_alu));
      OP_BLTU: res = XLEN'(rs1_alu < rs2_alu);
      OP_BGEU: res = XLEN'(rs1_alu >= rs2_alu);
      OP_JALR: res = (rs1_alu + rs2_alu) & ~XLEN'(1);
      // Unknown (and MUL-class when the multiplier is absent) broadcasts 0 so the ROB entry retires.
      default: res = '0;
    endcase
  end

  // A countdown of MUL_LAT-1 needs MUL_LAT >= 2; anything less has no valid multiplier timing.
  if (MUL_LAT < 2) begin : g_mul_lat_too_small
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(MUL_LAT);
  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             mul_start, mul_done;
  logic [XLEN-1:0]  mul_prod;

  assign mul_start = rdy & ~clr & flag_alu & (state_q == S_IDLE) & is_mul_op(op_alu);

  alu_mul_seq #(.XLEN(XLEN)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (clr),
    .start_i   (mul_start),
    .a_i       (rs1_alu),
    .b_i       (rs2_alu),
    .mode_i    (mul_mode(op_alu)),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= False;
      flag_q  <= False;
      tag_q   <= '0;
      ans_q   <= '0;
    end else if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= False;
      flag_q  <= False;
    end else if (!rdy) begin
      flag_q <= False;
    end else begin
      case (state_q)
        S_IDLE: begin
          flag_q <= False;
          if (flag_alu) begin
            tag_q <= rob_alu;
            if (is_mul_op(op_alu)) begin
              state_q <= S_MUL;
              cnt_q   <= CNT_W'(MUL_LAT - 1);
              busy_q  <= True;
            end else begin
              flag_q <= True;
              ans_q  <= res;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == '0 && mul_done) begin
            state_q <= S_IDLE;
            busy_q  <= False;
            flag_q  <= True;
            ans_q   <= mul_prod;
          end else begin
            cnt_q  <= cnt_q - 1'b1;
            flag_q <= False;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_busy = busy_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= False;
      tag_q  <= '0;
      ans_q  <= '0;
    end else if (clr || !rdy || !flag_alu) begin
      flag_q <= False;
    end else begin
      flag_q <= True;
      tag_q  <= rob_alu;
      ans_q  <= res;
    end
  end

  assign alu_busy = False;
`endif

  assign alu_ans_flag    = flag_q;
  assign alu_ans_reorder = tag_q;
  assign alu_ans         = ans_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes (tag, value, cycle) expectations,
// a negedge monitor pops and compares each CDB broadcast.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, clr = 1'b0, flag_alu = 1'b0;
  logic [5:0]  op_alu = '0;
  logic [31:0] rs1_alu = '0, rs2_alu = '0;
  logic [3:0]  rob_alu = '0;
  logic        alu_busy, alu_ans_flag;
  logic [3:0]  alu_ans_reorder;
  logic [31:0] alu_ans;

  alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clr(clr), .flag_alu(flag_alu),
    .op_alu(op_alu), .rs1_alu(rs1_alu), .rs2_alu(rs2_alu), .rob_alu(rob_alu),
    .alu_busy(alu_busy), .alu_ans_flag(alu_ans_flag),
    .alu_ans_reorder(alu_ans_reorder), .alu_ans(alu_ans)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one op at a negedge; accepted at the following posedge.
  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    @(negedge clk);
    flag_alu = 1'b1; op_alu = op; rs1_alu = a; rs2_alu = b; rob_alu = tag;
  endtask

  // extra = edges between the accept edge and the broadcast edge (0 for single-cycle ops).
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] val, input int extra);
    drive(op, a, b, tag);
    sb.push_back('{tag: tag, val: val, cyc: cyc + 1 + extra});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      flag_alu = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (flag_alu && alu_busy) begin
        n_tests++; n_fail++;
        $display("FAIL protocol: op issued while alu_busy=1");
      end
      if (alu_ans_flag) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_broadcast: tag=%0d ans=0x%0h at cycle %0d, none expected",
                   alu_ans_reorder, alu_ans, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (alu_ans_reorder !== e.tag || alu_ans !== e.val || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL cdb: got tag=%0d ans=0x%0h cyc=%0d expected tag=%0d ans=0x%0h cyc=%0d",
                     alu_ans_reorder, alu_ans, cyc, e.tag, e.val, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_flag",    32'(alu_ans_flag),    32'd0);
    check("reset_busy",    32'(alu_busy),        32'd0);
    check("reset_reorder", 32'(alu_ans_reorder), 32'd0);
    check("reset_ans",     alu_ans,              32'd0);
    rst_n = 1'b1;

    issue(OP_ADD, 32'd5, 32'd7, 4'd3, 32'd12, 0);
    idle(2);
    check("add_flag_clears", 32'(alu_ans_flag), 32'd0);

    // back-to-back: one result per cycle
    issue(OP_SUB,  32'd5,        32'd7,        4'd1,  32'hFFFF_FFFE, 0);
    issue(OP_SLL,  32'd1,        32'h25,       4'd2,  32'h20,        0);
    issue(OP_SLT,  32'd1,        32'hFFFF_FFFF, 4'd3, 32'd0,         0);
    issue(OP_SLTU, 32'd1,        32'hFFFF_FFFF, 4'd4, 32'd1,         0);
    issue(OP_XOR,  32'hF0F0,     32'hFF00,     4'd5,  32'h0FF0,      0);
    issue(OP_SRL,  32'h8000_0000, 32'd4,       4'd6,  32'h0800_0000, 0);
    issue(OP_SRA,  32'h8000_0000, 32'd4,       4'd7,  32'hF800_0000, 0);
    issue(OP_OR,   32'hF0,       32'h0F,       4'd8,  32'hFF,        0);
    issue(OP_AND,  32'hF0,       32'h3C,       4'd9,  32'h30,        0);
    issue(OP_BEQ,  32'd3,        32'd3,        4'd10, 32'd1,         0);
    issue(OP_BNE,  32'd3,        32'd3,        4'd11, 32'd0,         0);
    issue(OP_BLT,  32'hFFFF_FFFF, 32'd1,       4'd12, 32'd1,         0);
    issue(OP_BGE,  32'hFFFF_FFFF, 32'd1,       4'd13, 32'd0,         0);
    issue(OP_BLTU, 32'hFFFF_FFFF, 32'd1,       4'd14, 32'd0,         0);
    issue(OP_BGEU, 32'hFFFF_FFFF, 32'd1,       4'd15, 32'd1,         0);
    issue(OP_JALR, 32'h1003,     32'd4,        4'd0,  32'h1006,      0);
    issue(6'h3F,   32'h1234,     32'h5678,     4'd9,  32'd0,         0);
    issue(OP_ADD,  32'hFFFF_FFFF, 32'd1,       4'd1,  32'd0,         0);
    idle(2);

    // rdy=0 and clr each drop an op presented on the same edge
    drive(OP_ADD, 32'd9, 32'd9, 4'd2);
    rdy = 1'b0;
    @(negedge clk); rdy = 1'b1; flag_alu = 1'b0;
    drive(OP_ADD, 32'd8, 32'd8, 4'd3);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0; flag_alu = 1'b0;
    idle(2);

`ifdef ALU_MUL_EN
    issue(OP_MULH, 32'hFFFF_FFFF, 32'd2, 4'd5, 32'hFFFF_FFFF, 3);
    @(negedge clk); flag_alu = 1'b0;
    check("mulh_busy_c1", 32'(alu_busy), 32'd1);
    @(negedge clk); check("mulh_busy_c2", 32'(alu_busy), 32'd1);
    @(negedge clk); check("mulh_busy_c3", 32'(alu_busy), 32'd1);
    @(negedge clk); check("mulh_busy_done", 32'(alu_busy), 32'd0);
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd2, 4'd6, 32'hFFFF_FFFE, 3);
    idle(4);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 4'd7, 32'd1, 3);
    idle(4);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 4'd8, 32'hFFFF_FFFF, 3);
    idle(4);

    // clr one cycle after accept: dropped, no broadcast
    drive(OP_MUL, 32'd3, 32'd3, 4'd4);
    @(negedge clk); flag_alu = 1'b0; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("clr_mul_busy", 32'(alu_busy), 32'd0);
    idle(5);

    // two rdy-low cycles mid-MUL push the result two cycles later
    issue(OP_MUL, 32'd6, 32'd7, 4'd11, 32'd42, 5);
    @(negedge clk); flag_alu = 1'b0; rdy = 1'b0;
    @(negedge clk); check("stall_busy", 32'(alu_busy), 32'd1);
    @(negedge clk); rdy = 1'b1;
    idle(5);

    // async reset mid-MUL
    drive(OP_MULH, 32'd5, 32'd5, 4'd12);
    @(negedge clk); flag_alu = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("rst_mid_mul_busy", 32'(alu_busy), 32'd0);
    check("rst_mid_mul_flag", 32'(alu_ans_flag), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(5);
`else
    // without the multiplier a MUL-class op is an unknown single-cycle op
    issue(OP_MUL, 32'd6, 32'd7, 4'd2, 32'd0, 0);
    @(negedge clk); flag_alu = 1'b0;
    check("nomul_busy", 32'(alu_busy), 32'd0);
    idle(1);
`endif

    // async reset while a result is on the CDB
    issue(OP_ADD, 32'd2, 32'd3, 4'd13, 32'd5, 0);
    @(negedge clk); flag_alu = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("rst_mid_op_flag", 32'(alu_ans_flag), 32'd0);
    check("rst_mid_op_ans", alu_ans, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    issue(OP_ADD, 32'd1, 32'd1, 4'd14, 32'd2, 0);
    idle(3);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
